// File: rtl/conware_board_streamer.sv
// rtl/conware_board_streamer.sv - generation driver for the conware core
// Streams the board out as colour words, decodes the returned frame and iterates.
module conware_board_streamer #(
  parameter int                DWIDTH      = 32,
  parameter int                WIDTH       = 8,
  parameter logic [DWIDTH-1:0] ALIVE_COLOR = 32'hFFFFFFFF,
  parameter logic [DWIDTH-1:0] DEAD_COLOR  = 32'h00000000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [WIDTH-1:0]      seed_data,
  input  logic                  seed_load,
  input  logic [15:0]           num_gens,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      board_out,
  output logic [15:0]           gen_cnt,
  output logic                  rx_error,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DWIDTH-1:0]     M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic [DWIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic [DWIDTH/8-1:0]   M_AXIS_TSTRB,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [DWIDTH-1:0]     S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n, board_n;
  logic [IDXW-1:0]  tx_idx, tx_n, rx_idx, rx_n;
  logic [15:0]      gens_target, target_n, gen_n;
  logic             err_n, done_n, rx_bit;

  assign M_AXIS_TKEEP = '1;
  assign M_AXIS_TSTRB = '1;

  always_comb begin
    state_n  = state;
    board_n  = board_out;
    shadow_n = shadow;
    tx_n     = tx_idx;
    rx_n     = rx_idx;
    gen_n    = gen_cnt;
    target_n = gens_target;
    err_n    = rx_error;
    done_n   = 1'b0;
    rx_bit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (seed_load) board_n = seed_data;
        if (start) begin
          target_n = num_gens;
          gen_n    = '0;
          err_n    = 1'b0;
          if (num_gens == 16'd0) begin
            done_n = 1'b1;
          end else begin
            state_n = S_SEND;
            tx_n    = '0;
          end
        end
      end
      S_SEND: begin
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          if (tx_idx == LAST_IDX) begin
            state_n = S_RECV;
            rx_n    = '0;
          end else begin
            tx_n = tx_idx + 1'b1;
          end
        end
      end
      S_RECV: begin
        if (S_AXIS_TVALID && S_AXIS_TREADY) begin
          rx_bit = (S_AXIS_TDATA == ALIVE_COLOR);
          if (!rx_bit && (S_AXIS_TDATA != DEAD_COLOR)) err_n = 1'b1;
          // Frame length is fixed by WIDTH; TLAST is only cross-checked.
          if (S_AXIS_TLAST != (rx_idx == LAST_IDX)) err_n = 1'b1;
          shadow_n[rx_idx] = rx_bit;
          if (rx_idx == LAST_IDX) begin
            board_n = shadow_n;
            gen_n   = gen_cnt + 16'd1;
            if (gen_n == gens_target) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = S_SEND;
              tx_n    = '0;
            end
          end else begin
            rx_n = rx_idx + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stream outputs are registered from next-state values so they change only on edges.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= S_IDLE;
      board_out     <= '0;
      shadow        <= '0;
      tx_idx        <= '0;
      rx_idx        <= '0;
      gen_cnt       <= '0;
      gens_target   <= '0;
      rx_error      <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      S_AXIS_TREADY <= 1'b0;
    end else begin
      state         <= state_n;
      board_out     <= board_n;
      shadow        <= shadow_n;
      tx_idx        <= tx_n;
      rx_idx        <= rx_n;
      gen_cnt       <= gen_n;
      gens_target   <= target_n;
      rx_error      <= err_n;
      done          <= done_n;
      busy          <= (state_n != S_IDLE);
      M_AXIS_TVALID <= (state_n == S_SEND);
      M_AXIS_TDATA  <= (state_n == S_SEND) ? (board_n[tx_n] ? ALIVE_COLOR : DEAD_COLOR) : '0;
      M_AXIS_TLAST  <= (state_n == S_SEND) && (tx_n == LAST_IDX);
      S_AXIS_TREADY <= (state_n == S_RECV);
    end
  end

endmodule
